// File: rtl/fibonacci_seq_gen.sv
// Fibonacci sequence generator: produces term(0)..term(n) from two seeds, one term per clock,
// either streaming every term or presenting only term(n), with a sticky carry-out flag per run.
module fibonacci_seq_gen #(
    parameter int WIDTH  = 8,
    parameter int NWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NWIDTH-1:0] n,
    input  logic [WIDTH-1:0]  seed_a,
    input  logic [WIDTH-1:0]  seed_b,
    input  logic              stream,
    output logic [WIDTH-1:0]  fib,
    output logic              valid,
    output logic              done,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [NWIDTH-1:0]  cnt_q;
    logic [NWIDTH-1:0]  n_q;
    logic               stream_q;
    logic [WIDTH-1:0]   fib_q;
    logic               valid_q;
    logic               done_q;
    logic               busy_q;
    logic               overflow_q;

    logic [WIDTH:0]     term_d;
    logic [NWIDTH:0]    cnt_plus2;
    logic               last_term;
    logic               carry_counts;

    // a_q holds term(cnt_q); the adder forms term(cnt_q+2), which only matters while that index is <= n.
    assign term_d       = {1'b0, a_q} + {1'b0, b_q};
    assign cnt_plus2    = {1'b0, cnt_q} + (NWIDTH + 1)'(2);
    assign last_term    = (cnt_q == n_q);
    assign carry_counts = term_d[WIDTH] && (cnt_plus2 <= {1'b0, n_q});

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking would make a_q/b_q shift read freshly written data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
            stream_q   <= 1'b0;
            fib_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    // Accepting start in DONE lets runs go back-to-back without an idle cycle.
                    if (start) begin
                        state_q    <= RUN;
                        a_q        <= seed_a;
                        b_q        <= seed_b;
                        cnt_q      <= '0;
                        n_q        <= n;
                        stream_q   <= stream;
                        busy_q     <= 1'b1;
                        overflow_q <= 1'b0;
                    end
                end

                RUN: begin
                    a_q   <= b_q;
                    b_q   <= term_d[WIDTH-1:0];
                    cnt_q <= cnt_q + NWIDTH'(1);
                    if (carry_counts) begin
                        overflow_q <= 1'b1;
                    end
                    if (stream_q || last_term) begin
                        fib_q   <= a_q;
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                    if (last_term) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fib      = fib_q;
    assign valid    = valid_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fibonacci_seq_gen.sv
// Directed bench for fibonacci_seq_gen: latency, single/stream modes, overflow, start
// handling while busy and in the done cycle, and asynchronous reset mid-run.
module tb_fibonacci_seq_gen;

    localparam int WIDTH  = 8;
    localparam int NWIDTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NWIDTH-1:0] n;
    logic [WIDTH-1:0]  seed_a;
    logic [WIDTH-1:0]  seed_b;
    logic              stream;
    logic [WIDTH-1:0]  fib;
    logic              valid;
    logic              done;
    logic              busy;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    int lat;
    int nvalid;
    logic seen;
    logic [WIDTH-1:0] got_q[$];

    fibonacci_seq_gen #(.WIDTH(WIDTH), .NWIDTH(NWIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (n),
        .seed_a   (seed_a),
        .seed_b   (seed_b),
        .stream   (stream),
        .fib      (fib),
        .valid    (valid),
        .done     (done),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Presents a request across one rising edge (E0), then scrambles the inputs so any
    // re-sampling during the run would corrupt the result.
    task automatic do_start(input logic [NWIDTH-1:0] nn, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic s);
        n      = nn;
        seed_a = a;
        seed_b = b;
        stream = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        n      = NWIDTH'($urandom);
        seed_a = WIDTH'($urandom);
        seed_b = WIDTH'($urandom);
        stream = 1'($urandom);
    endtask

    // Steps edge by edge until done, recording latency and every valid term; leaves us in the done cycle.
    task automatic wait_final(input string tag, input int budget);
        lat    = 0;
        nvalid = 0;
        seen   = 1'b0;
        got_q.delete();
        while (!seen && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid) begin
                nvalid++;
                got_q.push_back(fib);
            end
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic idle_after(input string tag, input logic [WIDTH-1:0] exp_fib, input logic exp_ovf);
        @(posedge clk);
        #1;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(valid), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_fib"}, 32'(fib), 32'(exp_fib));
        check({tag, "_idle_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    logic [WIDTH-1:0] exp_stream [6] = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd7, 8'd11};
    logic [31:0] v;
    int done_cnt;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        n      = '0;
        seed_a = '0;
        seed_b = '0;
        stream = 1'b0;
        #3;
        check("reset_fib", 32'(fib), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single mode, n=10: 55 after eleven edges.
        do_start(8'd10, 8'd0, 8'd1, 1'b0);
        check("n10_busy_after_start", 32'(busy), 32'd1);
        wait_final("n10", 40);
        check("n10_latency", 32'(lat), 32'd11);
        check("n10_fib", 32'(fib), 32'd55);
        check("n10_valid", 32'(valid), 32'd1);
        check("n10_nvalid", 32'(nvalid), 32'd1);
        check("n10_ovf", 32'(overflow), 32'd0);
        check("n10_busy_done", 32'(busy), 32'd1);
        idle_after("n10", 8'd55, 1'b0);

        // n=13 fits; the next term would overflow but lies beyond n.
        do_start(8'd13, 8'd0, 8'd1, 1'b0);
        wait_final("n13", 40);
        check("n13_fib", 32'(fib), 32'd233);
        check("n13_ovf", 32'(overflow), 32'd0);
        idle_after("n13", 8'd233, 1'b0);

        do_start(8'd14, 8'd0, 8'd1, 1'b0);
        wait_final("n14", 40);
        check("n14_latency", 32'(lat), 32'd15);
        check("n14_fib", 32'(fib), 32'd121);
        check("n14_ovf", 32'(overflow), 32'd1);
        idle_after("n14", 8'd121, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("n14_ovf_held", 32'(overflow), 32'd1);

        do_start(8'd2, 8'd0, 8'd1, 1'b0);
        check("ovf_cleared_on_start", 32'(overflow), 32'd0);
        wait_final("n2", 20);
        check("n2_latency", 32'(lat), 32'd3);
        check("n2_fib", 32'(fib), 32'd1);
        idle_after("n2", 8'd1, 1'b0);

        // Stream mode, seeds 2/1, n=5.
        do_start(8'd5, 8'd2, 8'd1, 1'b1);
        wait_final("stream", 20);
        check("stream_latency", 32'(lat), 32'd6);
        check("stream_nvalid", 32'(nvalid), 32'd6);
        for (int i = 0; i < 6; i++) begin
            v = (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
            check($sformatf("stream_term%0d", i), v, 32'(exp_stream[i]));
        end
        idle_after("stream", 8'd11, 1'b0);

        // Boundary indices n=0 and n=1.
        do_start(8'd0, 8'd9, 8'd3, 1'b0);
        wait_final("n0", 10);
        check("n0_latency", 32'(lat), 32'd1);
        check("n0_fib", 32'(fib), 32'd9);
        idle_after("n0", 8'd9, 1'b0);

        do_start(8'd1, 8'd7, 8'd4, 1'b0);
        wait_final("n1", 10);
        check("n1_latency", 32'(lat), 32'd2);
        check("n1_fib", 32'(fib), 32'd4);
        idle_after("n1", 8'd4, 1'b0);

        // Start pulsed mid-run is ignored.
        do_start(8'd10, 8'd0, 8'd1, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n      = 8'd3;
        seed_a = 8'd5;
        seed_b = 8'd5;
        stream = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_final("midstart", 40);
        check("midstart_latency", 32'(lat + 4), 32'd11);
        check("midstart_fib", 32'(fib), 32'd55);
        check("midstart_nvalid", 32'(nvalid), 32'd1);

        // Back-to-back: start accepted in the done cycle.
        do_start(8'd3, 8'd0, 8'd1, 1'b0);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_valid", 32'(valid), 32'd0);
        check("b2b_done", 32'(done), 32'd0);
        wait_final("b2b", 20);
        check("b2b_latency", 32'(lat), 32'd4);
        check("b2b_fib", 32'(fib), 32'd2);
        idle_after("b2b", 8'd2, 1'b0);

        // Asynchronous reset between edges during a streaming run.
        do_start(8'd10, 8'd0, 8'd1, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("prerst_fib", 32'(fib), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_fib", 32'(fib), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        #1;
        rst = 1'b0;
        done_cnt = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_busy_after", 32'(busy), 32'd0);

        do_start(8'd6, 8'd0, 8'd1, 1'b0);
        wait_final("postrst", 20);
        check("postrst_latency", 32'(lat), 32'd7);
        check("postrst_fib", 32'(fib), 32'd8);
        idle_after("postrst", 8'd8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
